// File: rtl/pkg_ram.sv
// Request encodings and access-size helper shared by the RAM access controller and its bench.
package pkg_ram;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        WORD = 2'd1,
        LONG = 2'd2,
        QUAD = 2'd3
    } data_type_t;

    function automatic int type_bytes(input data_type_t t);
        int n;
        unique case (t)
            BYTE:    n = 1;
            WORD:    n = 2;
            LONG:    n = 4;
            default: n = 8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Single-port word array with per-byte write enables and a registered (1-cycle) read.
module ram_bank #(
    parameter int ADDRW = 12,
    parameter int DATAW = 32
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [DATAW/8-1:0]                    be,
    input  logic [ADDRW-$clog2(DATAW/8)-1:0]      widx,
    input  logic [DATAW-1:0]                      wdata,
    output logic [DATAW-1:0]                      rdata
);
    localparam int NB   = DATAW / 8;
    localparam int IDXW = ADDRW - $clog2(NB);

    logic [DATAW-1:0] mem_q [2**IDXW];

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we && be[b]) begin
                mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem_q[widx];
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Byte-addressed load/store front end: splits unaligned accesses into up to two word beats
// on ram_bank, rotates byte lanes, and merges/extends load data into a one-cycle response.
module ram_access_ctrl
    import pkg_ram::*;
#(
    parameter int ADDRW = 12,
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  op_t              op,
    input  data_type_t       data_type,
    input  logic             sx,
    input  logic [ADDRW-1:0] addr,
    input  logic [DATAW-1:0] data_in,
    output logic             rsp_valid,
    output logic [DATAW-1:0] data_out,
    output logic             err
);
    localparam int NB   = DATAW / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = ADDRW - OFFW;

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

    state_e           state_q, state_d;
    op_t              op_q, op_d;
    data_type_t       type_q, type_d;
    logic             sx_q, sx_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [DATAW-1:0] wr_q, wr_d;
    logic [DATAW-1:0] ld_q, ld_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             err_q, err_d;
    logic [DATAW-1:0] data_out_q, data_out_d;

    logic [OFFW-1:0]  off, lane;
    logic [IDXW-1:0]  idx0, idx1, widx;
    int               off_i, nb_c;
    logic             split, is_store, we, msb;
    logic [NB-1:0]    be0, be1, be, m0, m1;
    logic [DATAW-1:0] rdata, rd_rot, wdata, ext;

    always_comb begin
        off      = addr_q[OFFW-1:0];
        off_i    = int'(off);
        nb_c     = (type_bytes(type_q) > NB) ? NB : type_bytes(type_q);
        idx0     = addr_q[ADDRW-1:OFFW];
        idx1     = idx0 + IDXW'(1);
        is_store = (op_q == STORE);
        split    = (off_i + nb_c) > NB;
        lane     = '0;
        // be*: lane k of the RAM word; m*: result byte k, which lives in lane (k + off).
        for (int k = 0; k < NB; k++) begin
            be0[k] = (k >= off_i) && (k - off_i < nb_c);
            be1[k] = (k + NB - off_i) < nb_c;
            m0[k]  = (k < nb_c) && (k + off_i < NB);
            m1[k]  = (k < nb_c) && (k + off_i >= NB);
            lane   = OFFW'(k) + off;
            rd_rot[8*k +: 8] = rdata[{lane, 3'b000} +: 8];
            lane   = OFFW'(k) - off;
            wdata[8*k +: 8]  = wr_q[{lane, 3'b000} +: 8];
        end
    end

    // Loads address the next beat's word one cycle early to hide the synchronous read.
    always_comb begin
        widx = idx0;
        we   = 1'b0;
        be   = '0;
        unique case (state_q)
            StIdle:  widx = addr[ADDRW-1:OFFW];
            StBeat0: begin
                if (is_store) begin
                    we = !rst;
                    be = be0;
                end else begin
                    widx = idx1;
                end
            end
            StBeat1: begin
                widx = idx1;
                we   = is_store && !rst;
                be   = be1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        type_d      = type_q;
        sx_d        = sx_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        ld_d        = ld_q;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        data_out_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (req_valid && (op == LOAD || op == STORE)) begin
                    op_d   = op;
                    type_d = data_type;
                    sx_d   = sx;
                    addr_d = addr;
                    wr_d   = data_in;
                    if (type_bytes(data_type) > NB) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        state_d = StBeat0;
                    end
                end
            end
            StBeat0: begin
                for (int k = 0; k < NB; k++) begin
                    ld_d[8*k +: 8] = m0[k] ? rd_rot[8*k +: 8] : 8'h00;
                end
                state_d     = split ? StBeat1 : StResp;
                rsp_valid_d = !split;
            end
            StBeat1: begin
                for (int k = 0; k < NB; k++) begin
                    if (m1[k]) ld_d[8*k +: 8] = rd_rot[8*k +: 8];
                end
                state_d     = StResp;
                rsp_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        msb = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (k == nb_c - 1) msb = ld_d[8*k + 7];
        end
        for (int i = 0; i < DATAW; i++) begin
            ext[i] = (i < 8 * nb_c) ? ld_d[i] : (sx_q & msb);
        end
        if (rsp_valid_d && !err_d && op_q == LOAD) data_out_d = ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            data_out_q  <= data_out_d;
        end
        op_q   <= op_d;
        type_q <= type_d;
        sx_q   <= sx_d;
        addr_q <= addr_d;
        wr_q   <= wr_d;
        ld_q   <= ld_d;
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign err       = err_q;
    assign data_out  = data_out_q;

    ram_bank #(
        .ADDRW(ADDRW),
        .DATAW(DATAW)
    ) u_bank (
        .clk  (clk),
        .we   (we),
        .be   (be),
        .widx (widx),
        .wdata(wdata),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl (ADDRW=8, DATAW=32): directed cases plus random traffic
// checked against a byte-array memory model.
module tb_ram_access_ctrl;
    import pkg_ram::*;

    localparam int ADDRW = 8;
    localparam int DATAW = 32;

    logic             clk = 1'b0;
    logic             rst, req_valid, req_ready, sx, rsp_valid, err;
    op_t              op;
    data_type_t       data_type;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data_in, data_out;

    int tests = 0;
    int fails = 0;
    int mem_m [256];

    always #5 clk = ~clk;

    ram_access_ctrl #(
        .ADDRW(ADDRW),
        .DATAW(DATAW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .op       (op),
        .data_type(data_type),
        .sx       (sx),
        .addr     (addr),
        .data_in  (data_in),
        .rsp_valid(rsp_valid),
        .data_out (data_out),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input int a, input int n, input logic s);
        longint v;
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(mem_m[(a + k) % 256]) << (8 * k);
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v += (longint'(1) << 32) - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic m_store(input int a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) mem_m[(a + k) % 256] = int'((d >> (8 * k)) & 32'hFF);
    endtask

    task automatic xact(input op_t o, input data_type_t t, input logic s, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic re,
                        output int lat);
        int waited;
        waited = 0;
        while (!req_ready && waited < 16) begin
            @(posedge clk); #1;
            waited++;
        end
        req_valid = 1'b1; op = o; data_type = t; sx = s; addr = a; data_in = d;
        @(posedge clk); #1;
        req_valid = 1'b0; op = NOP;
        rd = '0; re = 1'b0; lat = 0;
        for (int c = 1; c <= 6; c++) begin
            if (rsp_valid === 1'b1) begin
                lat = c; rd = data_out; re = err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input op_t o, input data_type_t t, input logic s, input int a,
                       input logic [31:0] d, output logic [31:0] rd);
        int         n, lat;
        logic       re, exp_e;
        logic [31:0] exp_d;
        n     = 1 << int'(t);
        exp_e = (n > 4);
        exp_d = '0;
        if (!exp_e && o == LOAD)  exp_d = m_load(a, n, s);
        if (!exp_e && o == STORE) m_store(a, n, d);
        xact(o, t, s, 8'(a), d, rd, re, lat);
        check("err", 32'(re), 32'(exp_e));
        check("data", rd, exp_d);
        if (!exp_e) check("latency", 32'(lat), ((a % 4) + n > 4) ? 32'd3 : 32'd2);
        else        check("err_rsp_seen", 32'(lat != 0), 32'd1);
        @(posedge clk); #1;
        check("pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  r_op, r_ty;
        int          exp_b [4];
        int          wrap_a [4];
        exp_b  = '{4, 3, 2, 1};
        wrap_a = '{'hFE, 'hFF, 'h00, 'h01};

        rst = 1'b1; req_valid = 1'b0; op = NOP; data_type = BYTE; sx = 1'b0;
        addr = '0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        rst = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 64; i++) run(STORE, LONG, 1'b0, 4 * i, $urandom, rd);

        run(STORE, LONG, 1'b0, 'h10, 32'h11223344, rd);
        run(LOAD, LONG, 1'b0, 'h10, 32'h0, rd);
        check("aligned_long", rd, 32'h11223344);

        run(STORE, LONG, 1'b0, 'h0E, 32'hAABBCCDD, rd);
        run(LOAD, WORD, 1'b0, 'h0E, 32'h0, rd);
        check("split_lo_word", rd, 32'h0000CCDD);
        run(LOAD, WORD, 1'b0, 'h10, 32'h0, rd);
        check("split_hi_word", rd, 32'h0000AABB);
        run(LOAD, LONG, 1'b0, 'h0E, 32'h0, rd);
        check("split_long", rd, 32'hAABBCCDD);

        run(STORE, BYTE, 1'b0, 'h21, 32'h80, rd);
        run(LOAD, BYTE, 1'b1, 'h21, 32'h0, rd);
        check("byte_sx", rd, 32'hFFFFFF80);
        run(LOAD, BYTE, 1'b0, 'h21, 32'h0, rd);
        check("byte_zx", rd, 32'h00000080);
        run(LOAD, LONG, 1'b0, 'h20, 32'h0, rd);
        check("byte_lane1", 32'(rd[15:8]), 32'h80);

        run(STORE, LONG, 1'b0, 'hFE, 32'h01020304, rd);
        for (int i = 0; i < 4; i++) begin
            run(LOAD, BYTE, 1'b0, wrap_a[i], 32'h0, rd);
            check("wrap_byte", rd, 32'(exp_b[i]));
        end
        run(LOAD, LONG, 1'b0, 'hFE, 32'h0, rd);
        check("wrap_long", rd, 32'h01020304);

        run(STORE, QUAD, 1'b0, 'h40, 32'hFFFFFFFF, rd);
        run(LOAD, QUAD, 1'b1, 'h44, 32'h0, rd);
        run(LOAD, LONG, 1'b0, 'h40, 32'h0, rd);

        req_valid = 1'b1; op = NOP; data_type = LONG; addr = 8'h10; data_in = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("nop_rsp", 32'(rsp_valid), 32'd0);
            check("nop_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
        end

        // Split store to 0x0E interrupted by reset while writing word 0x10.
        req_valid = 1'b1; op = STORE; data_type = LONG; sx = 1'b0;
        addr = 8'h0E; data_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0; op = NOP;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rsp", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("abort_rsp_later", 32'(rsp_valid), 32'd0);
        run(LOAD, WORD, 1'b0, 'h10, 32'h0, rd);
        check("abort_untouched", rd, 32'h0000AABB);
        run(LOAD, LONG, 1'b0, 'h10, 32'h0, rd);
        run(STORE, LONG, 1'b0, 'h0C, $urandom, rd);

        for (int i = 0; i < 150; i++) begin
            r_op = 2'($urandom_range(1, 2));
            r_ty = 2'($urandom_range(0, 3));
            run(op_t'(r_op), data_type_t'(r_ty), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)), $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
